// File: rtl/adma_dm_width_conv_buf.sv
// rtl/adma_dm_width_conv_buf.sv - source-to-destination data buffer with FIFO and power-of-two width conversion
// Upsize packs narrow beats into wide words ahead of the FIFO; downsize splits wide words after it.
module adma_dm_width_conv_buf #(
  parameter int ATX_SRC_DATA_W = 256,
  parameter int ATX_DST_DATA_W = 64,
  parameter int BUF_DEPTH      = 8,
  localparam int STO_W = (ATX_SRC_DATA_W > ATX_DST_DATA_W) ? ATX_SRC_DATA_W : ATX_DST_DATA_W,
  localparam int MIN_W = (ATX_SRC_DATA_W < ATX_DST_DATA_W) ? ATX_SRC_DATA_W : ATX_DST_DATA_W,
  localparam int RATIO = STO_W / MIN_W,
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [ATX_SRC_DATA_W-1:0] src_data,
  input  logic                      src_last,
  input  logic                      src_vld,
  output logic                      src_rdy,
  output logic [ATX_DST_DATA_W-1:0] dst_data,
  output logic                      dst_last,
  output logic                      dst_vld,
  input  logic                      dst_rdy,
  output logic [CNT_W-1:0]          buf_cnt,
  output logic                      buf_full,
  output logic                      buf_empty
);

  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic [STO_W:0]     r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_src_fire;
  logic               w_dst_fire;
  logic               w_push;
  logic               w_pop;
  logic [STO_W:0]     w_push_word;
  logic [STO_W:0]     w_rd_word;

  assign buf_cnt    = r_cnt;
  assign buf_full   = (r_cnt == CNT_W'(BUF_DEPTH));
  assign buf_empty  = (r_cnt == '0);
  assign src_rdy    = !rst & !buf_full & !flush;
  assign dst_vld    = !buf_empty;
  assign w_rd_word  = r_mem[r_rd_ptr];
  assign w_src_fire = src_vld & src_rdy;
  assign w_dst_fire = dst_vld & dst_rdy;

  generate
    if (ATX_SRC_DATA_W < ATX_DST_DATA_W) begin : g_up
      localparam int LANE_W = $clog2(RATIO);
      localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
      logic [LANE_W-1:0] r_lane;
      logic [STO_W-1:0]  r_pack;
      logic [STO_W-1:0]  w_pack_next;

      always_comb begin
        w_pack_next = r_pack;
        w_pack_next[r_lane*ATX_SRC_DATA_W +: ATX_SRC_DATA_W] = src_data;
      end

      // A src_last beat closes the word early; unwritten upper lanes stay zero.
      assign w_push      = w_src_fire & ((r_lane == LAST_LANE) | src_last);
      assign w_push_word = {src_last, w_pack_next};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_lane <= '0;
          r_pack <= '0;
        end else if (flush) begin
          r_lane <= '0;
          r_pack <= '0;
        end else if (w_src_fire) begin
          if (w_push) begin
            r_lane <= '0;
            r_pack <= '0;
          end else begin
            r_lane <= r_lane + 1'b1;
            r_pack <= w_pack_next;
          end
        end
      end
    end else begin : g_no_up
      assign w_push      = w_src_fire;
      assign w_push_word = {src_last, src_data};
    end

    if (ATX_SRC_DATA_W > ATX_DST_DATA_W) begin : g_dn
      localparam int LANE_W = $clog2(RATIO);
      localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
      logic [LANE_W-1:0] r_sub;

      // Stored word leaves the FIFO only after its final sub-beat is taken.
      assign w_pop    = w_dst_fire & (r_sub == LAST_LANE);
      assign dst_data = dst_vld ? w_rd_word[r_sub*ATX_DST_DATA_W +: ATX_DST_DATA_W] : '0;
      assign dst_last = dst_vld & w_rd_word[STO_W] & (r_sub == LAST_LANE);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sub <= '0;
        end else if (flush) begin
          r_sub <= '0;
        end else if (w_dst_fire) begin
          r_sub <= (r_sub == LAST_LANE) ? '0 : r_sub + 1'b1;
        end
      end
    end else begin : g_no_dn
      assign w_pop    = w_dst_fire;
      assign dst_data = dst_vld ? w_rd_word[STO_W-1:0] : '0;
      assign dst_last = dst_vld & w_rd_word[STO_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push & !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_push & w_pop) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adma_dm_width_conv_buf.sv
// tb/tb_adma_dm_width_conv_buf.sv - scoreboard bench for equal, downsize and upsize buffer instances
module tb_adma_dm_width_conv_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic        eq_flush, eq_src_last, eq_src_vld, eq_src_rdy;
  logic        eq_dst_last, eq_dst_vld, eq_dst_rdy, eq_full, eq_empty;
  logic [31:0] eq_src_data, eq_dst_data;
  logic [2:0]  eq_cnt;

  logic         dn_flush, dn_src_last, dn_src_vld, dn_src_rdy;
  logic         dn_dst_last, dn_dst_vld, dn_dst_rdy, dn_full, dn_empty;
  logic [127:0] dn_src_data;
  logic [31:0]  dn_dst_data;
  logic [2:0]   dn_cnt;

  logic         up_flush, up_src_last, up_src_vld, up_src_rdy;
  logic         up_dst_last, up_dst_vld, up_dst_rdy, up_full, up_empty;
  logic [31:0]  up_src_data;
  logic [127:0] up_dst_data;
  logic [2:0]   up_cnt;

  logic [128:0] eq_q[$];
  logic [128:0] dn_q[$];
  logic [128:0] up_q[$];
  logic [128:0] eq_exp, dn_exp, up_exp;
  logic         dn_done;

  adma_dm_width_conv_buf #(.ATX_SRC_DATA_W(32), .ATX_DST_DATA_W(32), .BUF_DEPTH(4)) u_eq (
    .clk(clk), .rst(rst), .flush(eq_flush),
    .src_data(eq_src_data), .src_last(eq_src_last), .src_vld(eq_src_vld), .src_rdy(eq_src_rdy),
    .dst_data(eq_dst_data), .dst_last(eq_dst_last), .dst_vld(eq_dst_vld), .dst_rdy(eq_dst_rdy),
    .buf_cnt(eq_cnt), .buf_full(eq_full), .buf_empty(eq_empty));

  adma_dm_width_conv_buf #(.ATX_SRC_DATA_W(128), .ATX_DST_DATA_W(32), .BUF_DEPTH(4)) u_dn (
    .clk(clk), .rst(rst), .flush(dn_flush),
    .src_data(dn_src_data), .src_last(dn_src_last), .src_vld(dn_src_vld), .src_rdy(dn_src_rdy),
    .dst_data(dn_dst_data), .dst_last(dn_dst_last), .dst_vld(dn_dst_vld), .dst_rdy(dn_dst_rdy),
    .buf_cnt(dn_cnt), .buf_full(dn_full), .buf_empty(dn_empty));

  adma_dm_width_conv_buf #(.ATX_SRC_DATA_W(32), .ATX_DST_DATA_W(128), .BUF_DEPTH(4)) u_up (
    .clk(clk), .rst(rst), .flush(up_flush),
    .src_data(up_src_data), .src_last(up_src_last), .src_vld(up_src_vld), .src_rdy(up_src_rdy),
    .dst_data(up_dst_data), .dst_last(up_dst_last), .dst_vld(up_dst_vld), .dst_rdy(up_dst_rdy),
    .buf_cnt(up_cnt), .buf_full(up_full), .buf_empty(up_empty));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitors: pop the scoreboard whenever a destination handshake will occur at the next edge.
  always @(negedge clk) begin
    if (!rst && !eq_flush && eq_dst_vld && eq_dst_rdy) begin
      if (eq_q.size() == 0) fail_now("eq unexpected beat");
      else begin
        eq_exp = eq_q.pop_front();
        chk("eq data", 128'(eq_dst_data), eq_exp[127:0]);
        chk("eq last", 128'(eq_dst_last), 128'(eq_exp[128]));
      end
    end
    if (!rst && !dn_flush && dn_dst_vld && dn_dst_rdy) begin
      if (dn_q.size() == 0) fail_now("dn unexpected beat");
      else begin
        dn_exp = dn_q.pop_front();
        chk("dn data", 128'(dn_dst_data), dn_exp[127:0]);
        chk("dn last", 128'(dn_dst_last), 128'(dn_exp[128]));
      end
    end
    if (!rst && !up_flush && up_dst_vld && up_dst_rdy) begin
      if (up_q.size() == 0) fail_now("up unexpected beat");
      else begin
        up_exp = up_q.pop_front();
        chk("up data", up_dst_data, up_exp[127:0]);
        chk("up last", 128'(up_dst_last), 128'(up_exp[128]));
      end
    end
    if (!rst && dn_full) chk("dn src_rdy while full", 128'(dn_src_rdy), 128'(0));
  end

  task automatic send_eq(input logic [31:0] d, input logic l);
    eq_src_data = d; eq_src_last = l; eq_src_vld = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (eq_src_rdy) begin
        @(posedge clk); #1;
        eq_src_vld = 1'b0;
        return;
      end
    end
    fail_now("eq src accept timeout");
    eq_src_vld = 1'b0;
  endtask

  task automatic send_dn(input logic [127:0] d, input logic l);
    dn_src_data = d; dn_src_last = l; dn_src_vld = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dn_src_rdy) begin
        @(posedge clk); #1;
        dn_src_vld = 1'b0;
        return;
      end
    end
    fail_now("dn src accept timeout");
    dn_src_vld = 1'b0;
  endtask

  task automatic send_up(input logic [31:0] d, input logic l);
    up_src_data = d; up_src_last = l; up_src_vld = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (up_src_rdy) begin
        @(posedge clk); #1;
        up_src_vld = 1'b0;
        return;
      end
    end
    fail_now("up src accept timeout");
    up_src_vld = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (eq_q.size() == 0 && dn_q.size() == 0 && up_q.size() == 0 &&
          eq_empty && dn_empty && up_empty) return;
    end
    fail_now(name);
  endtask

  initial begin
    logic [127:0] w;
    logic         l;
    rst = 1'b1;
    eq_flush = 0; eq_src_data = 0; eq_src_last = 0; eq_src_vld = 0; eq_dst_rdy = 0;
    dn_flush = 0; dn_src_data = 0; dn_src_last = 0; dn_src_vld = 0; dn_dst_rdy = 0;
    up_flush = 0; up_src_data = 0; up_src_last = 0; up_src_vld = 0; up_dst_rdy = 0;
    dn_done = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset eq src_rdy", 128'(eq_src_rdy), 128'(0));
    chk("reset dn src_rdy", 128'(dn_src_rdy), 128'(0));
    chk("reset eq buf_cnt", 128'(eq_cnt), 128'(0));
    chk("reset eq buf_empty", 128'(eq_empty), 128'(1));
    chk("reset eq buf_full", 128'(eq_full), 128'(0));
    chk("reset up dst_vld", 128'(up_dst_vld), 128'(0));
    chk("reset dn dst_data", 128'(dn_dst_data), 128'(0));
    chk("reset dn dst_last", 128'(dn_dst_last), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-reset eq src_rdy", 128'(eq_src_rdy), 128'(1));

    // Equal widths: fill to full with the sink stalled, then drain in order.
    for (int k = 1; k <= 4; k++) begin
      eq_q.push_back({1'b0, 128'(k)});
      send_eq(32'(k), 1'b0);
    end
    chk("eq buf_full", 128'(eq_full), 128'(1));
    chk("eq buf_cnt full", 128'(eq_cnt), 128'(4));
    chk("eq src_rdy full", 128'(eq_src_rdy), 128'(0));
    eq_dst_rdy = 1'b1;
    drain("eq drain timeout");
    chk("eq buf_empty", 128'(eq_empty), 128'(1));

    // Downsize single tagged word.
    dn_dst_rdy = 1'b1;
    dn_q.push_back({1'b0, 128'h1});
    dn_q.push_back({1'b0, 128'h2});
    dn_q.push_back({1'b0, 128'h3});
    dn_q.push_back({1'b1, 128'h4});
    send_dn(128'h00000004_00000003_00000002_00000001, 1'b1);
    drain("dn drain timeout");
    chk("dn buf_cnt after", 128'(dn_cnt), 128'(0));

    // Upsize full word, short word, then lane-0 restart.
    up_dst_rdy = 1'b1;
    up_q.push_back({1'b1, 128'h0000000D_0000000C_0000000B_0000000A});
    send_up(32'hA, 1'b0);
    send_up(32'hB, 1'b0);
    send_up(32'hC, 1'b0);
    chk("up vld before last", 128'(up_dst_vld), 128'(0));
    send_up(32'hD, 1'b1);
    chk("up vld after last", 128'(up_dst_vld), 128'(1));
    drain("up drain timeout 1");
    up_q.push_back({1'b1, 128'h00000000_00000000_00000022_00000011});
    send_up(32'h11, 1'b0);
    send_up(32'h22, 1'b1);
    up_q.push_back({1'b1, 128'h00000000_00000000_00000000_00000033});
    send_up(32'h33, 1'b1);
    drain("up drain timeout 2");

    // Downsize streaming with a randomly stalling sink.
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          w = {$urandom, $urandom, $urandom, $urandom};
          l = (i % 8 == 7);
          dn_q.push_back({1'b0, 96'h0, w[31:0]});
          dn_q.push_back({1'b0, 96'h0, w[63:32]});
          dn_q.push_back({1'b0, 96'h0, w[95:64]});
          dn_q.push_back({l,    96'h0, w[127:96]});
          send_dn(w, l);
        end
        dn_done = 1'b1;
      end
      begin
        while (!dn_done) begin
          @(posedge clk); #1;
          dn_dst_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    dn_dst_rdy = 1'b1;
    drain("dn stream drain timeout");

    // Flush after two of four sub-beats; next word must start from lane 0.
    dn_dst_rdy = 1'b0;
    dn_q.push_back({1'b0, 128'hAAAAAAAA});
    dn_q.push_back({1'b0, 128'hBBBBBBBB});
    send_dn(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b1);
    dn_dst_rdy = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    dn_dst_rdy = 1'b0;
    dn_flush = 1'b1;
    @(negedge clk);
    chk("dn src_rdy during flush", 128'(dn_src_rdy), 128'(0));
    @(posedge clk); #1;
    dn_flush = 1'b0;
    chk("dn buf_cnt after flush", 128'(dn_cnt), 128'(0));
    chk("dn dst_vld after flush", 128'(dn_dst_vld), 128'(0));
    dn_dst_rdy = 1'b1;
    dn_q.push_back({1'b0, 128'h5});
    dn_q.push_back({1'b0, 128'h6});
    dn_q.push_back({1'b0, 128'h7});
    dn_q.push_back({1'b1, 128'h8});
    send_dn(128'h00000008_00000007_00000006_00000005, 1'b1);
    drain("dn post-flush drain timeout");

    // Reset mid-packing discards the partial word.
    send_up(32'h44, 1'b0);
    send_up(32'h55, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("up src_rdy in reset", 128'(up_src_rdy), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    chk("up buf_cnt after reset", 128'(up_cnt), 128'(0));
    chk("up dst_vld after reset", 128'(up_dst_vld), 128'(0));
    @(posedge clk); #1;
    up_q.push_back({1'b1, 128'h66});
    send_up(32'h66, 1'b1);
    drain("up post-reset drain timeout");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
